// File: rtl/soc_system_pcp_0_cpu_0_oci_dct_packer_if.sv
// Trace-atom input and DCT-frame output bundle of the OCI DCT packer.
// master = trace source plus frame consumer, slave = packer.
interface soc_system_pcp_0_cpu_0_oci_dct_packer_if #(
   parameter int ATOM_W = 2,
   parameter int DEPTH  = 15,
   parameter int CNT_W  = 4
);
   logic                      atom_valid;
   logic [ATOM_W-1:0]         atom_data;
   logic                      flush;
   logic                      test_ending;
   logic                      atom_ready;
   logic                      frame_valid;
   logic                      frame_ready;
   logic [ATOM_W*DEPTH-1:0]   frame_buffer;
   logic [CNT_W-1:0]          frame_count;

   modport master (
      output atom_valid, atom_data, flush, test_ending, frame_ready,
      input  atom_ready, frame_valid, frame_buffer, frame_count
   );

   modport slave (
      input  atom_valid, atom_data, flush, test_ending, frame_ready,
      output atom_ready, frame_valid, frame_buffer, frame_count
   );
endinterface

// File: rtl/soc_system_pcp_0_cpu_0_oci_dct_packer.sv
// Packs 2-bit trace atoms into 15-atom DCT frames; a closed frame reaches the output one edge later.
// A full output slot parks the closed frame (atom_ready=0); atoms arriving then are dropped and counted.
module soc_system_pcp_0_cpu_0_oci_dct_packer #(
   parameter int ATOM_W = 2,
   parameter int DEPTH  = 15,
   parameter int CNT_W  = 4,
   parameter int DROP_W = 8
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   soc_system_pcp_0_cpu_0_oci_dct_packer_if.slave trc,
   output logic [ATOM_W*DEPTH-1:0]       dct_buffer_o,
   output logic [CNT_W-1:0]              dct_count_o,
   output logic [DROP_W-1:0]             drop_count_o,
   output logic                          test_has_ended_o
);
   localparam int FRAME_W = ATOM_W * DEPTH;

   localparam logic [0:0] ST_ACC  = 1'b0;
   localparam logic [0:0] ST_PEND = 1'b1;

   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
   localparam logic [DROP_W-1:0] DROP_MAX = '1;

   logic [0:0]          state_q, state_d;
   logic [FRAME_W-1:0]  acc_buf_q, acc_buf_d;
   logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
   logic [FRAME_W-1:0]  frm_buf_q, frm_buf_d;
   logic [CNT_W-1:0]    frm_cnt_q, frm_cnt_d;
   logic                frm_vld_q, frm_vld_d;
   logic [DROP_W-1:0]   drop_q, drop_d;
   logic                end_armed_q, end_armed_d;
   logic                ended_q, ended_d;

   logic                atom_rdy;
   logic                slot_free;
   logic                accept;
   logic [FRAME_W-1:0]  post_buf;
   logic [CNT_W-1:0]    post_cnt;
   logic                close_req;
   logic                load;
   logic [FRAME_W-1:0]  load_buf;
   logic [CNT_W-1:0]    load_cnt;

   assign atom_rdy  = (state_q == ST_ACC);
   assign slot_free = !frm_vld_q || trc.frame_ready;
   assign accept    = trc.atom_valid && atom_rdy;

   // Accumulator as it stands after this cycle's atom, so a closing atom lands in its own frame.
   assign post_buf  = accept ? {acc_buf_q[FRAME_W-ATOM_W-1:0], trc.atom_data} : acc_buf_q;
   assign post_cnt  = acc_cnt_q + {{(CNT_W-1){1'b0}}, accept};
   assign close_req = (post_cnt == FULL_CNT) ||
                      ((trc.flush || trc.test_ending) && (post_cnt != '0));

   always_comb begin
      state_d   = state_q;
      acc_buf_d = acc_buf_q;
      acc_cnt_d = acc_cnt_q;
      load      = 1'b0;
      load_buf  = acc_buf_q;
      load_cnt  = acc_cnt_q;

      case (state_q)
         ST_ACC: begin
            acc_buf_d = post_buf;
            acc_cnt_d = post_cnt;
            if (close_req) begin
               if (slot_free) begin
                  load      = 1'b1;
                  load_buf  = post_buf;
                  load_cnt  = post_cnt;
                  acc_buf_d = '0;
                  acc_cnt_d = '0;
               end else begin
                  state_d = ST_PEND;
               end
            end
         end
         ST_PEND: begin
            if (slot_free) begin
               load      = 1'b1;
               acc_buf_d = '0;
               acc_cnt_d = '0;
               state_d   = ST_ACC;
            end
         end
         default: state_d = ST_ACC;
      endcase
   end

   always_comb begin
      frm_buf_d = frm_buf_q;
      frm_cnt_d = frm_cnt_q;
      frm_vld_d = frm_vld_q;
      if (load) begin
         frm_buf_d = load_buf;
         frm_cnt_d = load_cnt;
         frm_vld_d = 1'b1;
      end else if (trc.frame_ready) begin
         frm_vld_d = 1'b0;
      end
   end

   always_comb begin
      drop_d = drop_q;
      if (trc.atom_valid && !atom_rdy && (drop_q != DROP_MAX)) begin
         drop_d = drop_q + DROP_W'(1);
      end
   end

   // Finished only once nothing is left in the accumulator, parked, or unaccepted at the output.
   assign end_armed_d = end_armed_q || trc.test_ending;
   assign ended_d     = ended_q ||
                        (end_armed_q && (acc_cnt_q == '0) && (state_q == ST_ACC) && slot_free);

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q     <= ST_ACC;
         acc_buf_q   <= '0;
         acc_cnt_q   <= '0;
         frm_buf_q   <= '0;
         frm_cnt_q   <= '0;
         frm_vld_q   <= 1'b0;
         drop_q      <= '0;
         end_armed_q <= 1'b0;
         ended_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_buf_q   <= acc_buf_d;
         acc_cnt_q   <= acc_cnt_d;
         frm_buf_q   <= frm_buf_d;
         frm_cnt_q   <= frm_cnt_d;
         frm_vld_q   <= frm_vld_d;
         drop_q      <= drop_d;
         end_armed_q <= end_armed_d;
         ended_q     <= ended_d;
      end
   end

   assign trc.atom_ready   = atom_rdy;
   assign trc.frame_valid  = frm_vld_q;
   assign trc.frame_buffer = frm_buf_q;
   assign trc.frame_count  = frm_cnt_q;

   assign dct_buffer_o     = acc_buf_q;
   assign dct_count_o      = acc_cnt_q;
   assign drop_count_o     = drop_q;
   assign test_has_ended_o = ended_q;
endmodule

// File: tb/tb_soc_system_pcp_0_cpu_0_oci_dct_packer.sv
// Bench for the DCT packer: directed vectors, corner sequences and a queue-based reference model.
module tb_soc_system_pcp_0_cpu_0_oci_dct_packer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic [7:0]  drop_count;
   logic        test_has_ended;

   soc_system_pcp_0_cpu_0_oci_dct_packer_if ifc ();

   soc_system_pcp_0_cpu_0_oci_dct_packer dut (
      .clk_i            (clk),
      .reset_n_i        (reset_n),
      .trc              (ifc),
      .dct_buffer_o     (dct_buffer),
      .dct_count_o      (dct_count),
      .drop_count_o     (drop_count),
      .test_has_ended_o (test_has_ended)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: the accumulator is a list of atoms, the output slot a held frame.
   int          m_acc[$];
   bit          m_pend, m_hv, m_armed, m_ended;
   logic [29:0] m_hbuf;
   int          m_hcnt, m_drops;

   function automatic logic [29:0] pack_atoms(input int a[$]);
      logic [29:0] r = '0;
      foreach (a[i]) r = (r << 2) | 30'(a[i]);
      return r;
   endfunction

   task automatic model_reset();
      m_acc.delete();
      m_pend = 0; m_hv = 0; m_armed = 0; m_ended = 0;
      m_hbuf = '0; m_hcnt = 0; m_drops = 0;
   endtask

   task automatic model_step();
      bit rdy, slot, moved, en_next;
      rdy     = !m_pend;
      slot    = !m_hv || ifc.frame_ready;
      moved   = 0;
      en_next = m_ended || (m_armed && m_acc.size() == 0 && !m_pend && slot);
      if (ifc.atom_valid && !rdy && m_drops < 255) m_drops++;
      if (!m_pend) begin
         if (ifc.atom_valid) m_acc.push_back(int'(ifc.atom_data));
         if (m_acc.size() == 15 || ((ifc.flush || ifc.test_ending) && m_acc.size() > 0)) begin
            if (slot) moved = 1;
            else      m_pend = 1;
         end
      end else if (slot) begin
         moved  = 1;
         m_pend = 0;
      end
      if (moved) begin
         m_hbuf = pack_atoms(m_acc);
         m_hcnt = m_acc.size();
         m_hv   = 1;
         m_acc.delete();
      end else if (ifc.frame_ready) begin
         m_hv = 0;
      end
      if (ifc.test_ending) m_armed = 1;
      m_ended = en_next;
   endtask

   task automatic set_in(input bit av, input logic [1:0] ad, input bit fl, input bit te, input bit fr);
      ifc.atom_valid  = av;
      ifc.atom_data   = ad;
      ifc.flush       = fl;
      ifc.test_ending = te;
      ifc.frame_ready = fr;
   endtask

   task automatic tick();
      if (!reset_n) model_reset();
      else          model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_model();
      chk("rnd_atom_ready",  32'(ifc.atom_ready),   32'(!m_pend));
      chk("rnd_frame_valid", 32'(ifc.frame_valid),  32'(m_hv));
      chk("rnd_frame_buf",   32'(ifc.frame_buffer), 32'(m_hbuf));
      chk("rnd_frame_cnt",   32'(ifc.frame_count),  32'(m_hcnt));
      chk("rnd_dct_buf",     32'(dct_buffer),       32'(pack_atoms(m_acc)));
      chk("rnd_dct_cnt",     32'(dct_count),        32'(m_acc.size()));
      chk("rnd_drops",       32'(drop_count),       32'(m_drops));
      chk("rnd_ended",       32'(test_has_ended),   32'(m_ended));
   endtask

   typedef struct {
      bit          av;
      logic [1:0]  ad;
      bit          fl;
      bit          te;
      bit          fr;
      bit          e_fv;
      logic [29:0] e_fb;
      logic [3:0]  e_fc;
      logic [3:0]  e_dc;
   } vec_t;

   vec_t vecs[9];

   initial begin
      // Flush vectors; starting point is the frame left over from the 15-atom run.
      vecs[0] = '{1, 2'd3, 0, 0, 1, 0, 30'h15555555, 4'd15, 4'd1};
      vecs[1] = '{1, 2'd2, 0, 0, 1, 0, 30'h15555555, 4'd15, 4'd2};
      vecs[2] = '{1, 2'd1, 0, 0, 1, 0, 30'h15555555, 4'd15, 4'd3};
      vecs[3] = '{0, 2'd0, 1, 0, 1, 1, 30'h39,       4'd3,  4'd0};
      vecs[4] = '{0, 2'd0, 1, 0, 1, 0, 30'h39,       4'd3,  4'd0};
      vecs[5] = '{0, 2'd0, 0, 0, 1, 0, 30'h39,       4'd3,  4'd0};
      vecs[6] = '{1, 2'd2, 0, 0, 1, 0, 30'h39,       4'd3,  4'd1};
      vecs[7] = '{1, 2'd3, 1, 0, 1, 1, 30'hB,        4'd2,  4'd0};
      vecs[8] = '{0, 2'd0, 0, 0, 1, 0, 30'hB,        4'd2,  4'd0};

      reset_n = 1'b0;
      set_in(0, 2'd0, 0, 0, 0);
      tick();
      tick();
      reset_n = 1'b1;

      chk("rst_atom_ready",  32'(ifc.atom_ready),   32'd1);
      chk("rst_frame_valid", 32'(ifc.frame_valid),  32'd0);
      chk("rst_frame_buf",   32'(ifc.frame_buffer), 32'd0);
      chk("rst_dct_cnt",     32'(dct_count),        32'd0);
      chk("rst_drops",       32'(drop_count),       32'd0);
      chk("rst_ended",       32'(test_has_ended),   32'd0);

      // Fifteen consecutive atoms fill exactly one frame.
      for (int i = 0; i < 15; i++) begin
         set_in(1, 2'd1, 0, 0, 1);
         tick();
         if (i < 14) chk("t1_no_frame_yet", 32'(ifc.frame_valid), 32'd0);
      end
      chk("t1_frame_valid", 32'(ifc.frame_valid),  32'd1);
      chk("t1_frame_buf",   32'(ifc.frame_buffer), 32'h15555555);
      chk("t1_frame_cnt",   32'(ifc.frame_count),  32'd15);
      chk("t1_dct_cnt",     32'(dct_count),        32'd0);

      for (int i = 0; i < 9; i++) begin
         set_in(vecs[i].av, vecs[i].ad, vecs[i].fl, vecs[i].te, vecs[i].fr);
         tick();
         chk("vec_frame_valid", 32'(ifc.frame_valid),  32'(vecs[i].e_fv));
         chk("vec_frame_buf",   32'(ifc.frame_buffer), 32'(vecs[i].e_fb));
         chk("vec_frame_cnt",   32'(ifc.frame_count),  32'(vecs[i].e_fc));
         chk("vec_dct_cnt",     32'(dct_count),        32'(vecs[i].e_dc));
      end

      // Stalled consumer: frame 1 held, frame 2 parked, atom 31 dropped.
      for (int i = 0; i < 31; i++) begin
         set_in(1, (i < 15) ? 2'd2 : ((i < 30) ? 2'd3 : 2'd1), 0, 0, 0);
         tick();
      end
      chk("t4_frame_valid", 32'(ifc.frame_valid),  32'd1);
      chk("t4_frame1_buf",  32'(ifc.frame_buffer), 32'h2AAAAAAA);
      chk("t4_atom_ready",  32'(ifc.atom_ready),   32'd0);
      chk("t4_pend_cnt",    32'(dct_count),        32'd15);
      chk("t4_pend_buf",    32'(dct_buffer),       32'h3FFFFFFF);
      chk("t4_drops",       32'(drop_count),       32'd1);
      set_in(0, 2'd0, 0, 0, 1);
      tick();
      chk("t4_frame2_valid", 32'(ifc.frame_valid),  32'd1);
      chk("t4_frame2_buf",   32'(ifc.frame_buffer), 32'h3FFFFFFF);
      chk("t4_frame2_cnt",   32'(ifc.frame_count),  32'd15);
      chk("t4_ready_again",  32'(ifc.atom_ready),   32'd1);
      chk("t4_acc_empty",    32'(dct_count),        32'd0);
      tick();
      chk("t4_drained", 32'(ifc.frame_valid), 32'd0);

      // End of trace: test_ending closes a 5-atom frame; completion waits for its acceptance.
      for (int i = 0; i < 5; i++) begin
         set_in(1, 2'd1, 0, (i == 4), 0);
         tick();
      end
      chk("t5_frame_valid", 32'(ifc.frame_valid),  32'd1);
      chk("t5_frame_cnt",   32'(ifc.frame_count),  32'd5);
      chk("t5_frame_buf",   32'(ifc.frame_buffer), 32'h155);
      chk("t5_not_ended",   32'(test_has_ended),   32'd0);
      set_in(0, 2'd0, 0, 0, 0);
      tick();
      chk("t5_held_not_ended", 32'(test_has_ended), 32'd0);
      set_in(0, 2'd0, 0, 0, 1);
      tick();
      chk("t5_accepted", 32'(ifc.frame_valid), 32'd0);
      chk("t5_ended",    32'(test_has_ended),  32'd1);
      set_in(1, 2'd2, 0, 0, 0);
      tick();
      chk("t5_packs_after_end", 32'(dct_count), 32'd1);
      for (int i = 0; i < 29; i++) begin
         set_in(1, 2'd0, 0, 0, 0);
         tick();
      end
      chk("t5_sticky_ended", 32'(test_has_ended),  32'd1);
      chk("t5_parked",       32'(ifc.atom_ready),  32'd0);
      for (int i = 0; i < 300; i++) begin
         set_in(1, 2'd3, 0, 0, 0);
         tick();
      end
      chk("t5_drop_sat", 32'(drop_count), 32'd255);

      // Reset while a frame is held and another is parked.
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      set_in(0, 2'd0, 0, 0, 0);
      chk("t6_atom_ready",  32'(ifc.atom_ready),   32'd1);
      chk("t6_frame_valid", 32'(ifc.frame_valid),  32'd0);
      chk("t6_frame_buf",   32'(ifc.frame_buffer), 32'd0);
      chk("t6_frame_cnt",   32'(ifc.frame_count),  32'd0);
      chk("t6_dct_buf",     32'(dct_buffer),       32'd0);
      chk("t6_dct_cnt",     32'(dct_count),        32'd0);
      chk("t6_drops",       32'(drop_count),       32'd0);
      chk("t6_ended",       32'(test_has_ended),   32'd0);

      for (int i = 0; i < 4000; i++) begin
         reset_n = ($urandom_range(0, 999) != 0);
         set_in($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0,
                $urandom_range(0, 2) != 0);
         tick();
         check_model();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
